// File: rtl/instr_decode_stage.sv
// Registered decode stage of the 8-bit nRisc datapath: one-entry output register
// with valid/ready handshake, HALT latch and issued-instruction counter.
module instr_decode_stage #(
  parameter logic [3:0] HALT_OPC = 4'b1111,
  parameter int         CNT_W    = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       instr_in,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic             dec_ready,
  output logic             dec_valid,
  output logic [3:0]       opcode,
  output logic [1:0]       rd,
  output logic [1:0]       rs,
  output logic [1:0]       imm2,
  output logic [1:0]       alu_op,
  output logic             alu_src_imm,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             branch,
  output logic             jump,
  output logic             illegal,
  output logic             halted,
  output logic [CNT_W-1:0] issued_cnt
);

  typedef enum logic [1:0] {EMPTY, FULL, HALTING, HALTED} state_t;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src_imm;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       jump;
    logic       illegal;
  } ctrl_t;

  // HALT is tested first so a HALT_OPC override always wins over the table.
  function automatic ctrl_t decode(input logic [3:0] opc);
    ctrl_t c;
    c = '0;
    if (opc != HALT_OPC) begin
      case (opc)
        4'b0000: ;
        4'b0001: c.reg_write = 1'b1;
        4'b0010: begin c.reg_write = 1'b1; c.alu_op = 2'b01; end
        4'b0011: begin c.reg_write = 1'b1; c.alu_op = 2'b10; end
        4'b0100: begin c.reg_write = 1'b1; c.alu_op = 2'b11; end
        4'b0101: begin c.reg_write = 1'b1; c.alu_src_imm = 1'b1; end
        4'b0110: begin c.mem_read = 1'b1; c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
        4'b0111: c.mem_write = 1'b1;
        4'b1000: begin c.branch = 1'b1; c.alu_op = 2'b01; end
        4'b1001: c.jump = 1'b1;
        default: c.illegal = 1'b1;
      endcase
    end
    return c;
  endfunction

  state_t           state_p1, state_nx;
  ctrl_t            ctrl_p1;
  logic [3:0]       opcode_p1;
  logic [1:0]       rd_p1, rs_p1;
  logic             halted_p1;
  logic [CNT_W-1:0] cnt_p1;
  logic             load, out_xfer;

  assign dec_valid = (state_p1 == FULL) || (state_p1 == HALTING);
  assign load      = instr_valid && instr_ready;
  assign out_xfer  = dec_valid && dec_ready;

  always_comb begin
    state_nx    = state_p1;
    instr_ready = 1'b0;
    case (state_p1)
      EMPTY: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nx = (instr_in[7:4] == HALT_OPC) ? HALTING : FULL;
      end
      FULL: begin
        instr_ready = dec_ready;
        if (dec_ready && instr_valid)
          state_nx = (instr_in[7:4] == HALT_OPC) ? HALTING : FULL;
        else if (dec_ready)
          state_nx = EMPTY;
      end
      HALTING: if (dec_ready) state_nx = HALTED;
      HALTED:  state_nx = HALTED;
      default: state_nx = EMPTY;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_p1 <= EMPTY;
    else       state_p1 <= state_nx;
  end

  // Stage p1: output register, loaded only on an input transfer so a stall holds it.
  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_p1   <= '0;
      opcode_p1 <= '0;
      rd_p1     <= '0;
      rs_p1     <= '0;
      halted_p1 <= 1'b0;
      cnt_p1    <= '0;
    end else begin
      if (load) begin
        ctrl_p1   <= decode(instr_in[7:4]);
        opcode_p1 <= instr_in[7:4];
        rd_p1     <= instr_in[3:2];
        rs_p1     <= instr_in[1:0];
      end
      if (out_xfer) cnt_p1 <= cnt_p1 + CNT_W'(1);
      if ((state_p1 == HALTING) && dec_ready) halted_p1 <= 1'b1;
    end
  end

  assign opcode      = opcode_p1;
  assign rd          = rd_p1;
  assign rs          = rs_p1;
  assign imm2        = rs_p1;
  assign alu_op      = ctrl_p1.alu_op;
  assign alu_src_imm = ctrl_p1.alu_src_imm;
  assign reg_write   = ctrl_p1.reg_write;
  assign mem_read    = ctrl_p1.mem_read;
  assign mem_write   = ctrl_p1.mem_write;
  assign mem_to_reg  = ctrl_p1.mem_to_reg;
  assign branch      = ctrl_p1.branch;
  assign jump        = ctrl_p1.jump;
  assign illegal     = ctrl_p1.illegal;
  assign halted      = halted_p1;
  assign issued_cnt  = cnt_p1;

endmodule
